// File: rtl/zmod_rx_aligner.sv
// zmod_rx_aligner: word aligner for the zmod LVDS receive path.
//
// Hunts for the one-hot sync-lane byte, qualifies the same bit position over
// LOCK_COUNT consecutive bytes, then applies that bit shift to every data
// lane. While locked it watches the aligned sync word and drops lock after
// UNLOCK_COUNT consecutive bad words.
//
// Build option: define ZMOD_RX_CHECK_EN to build the per-lane
// incrementing-byte checker (check_err / check_err_cnt). Without it both
// checker outputs are tied to zero.
//
// fsm_state exposes the aligner state: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.
//
// Stream semantics: data_out carries aligned lane bytes every cycle.
// data_valid qualifies them. There is no ready; the stream cannot stall,
// so a byte is consumed on every cycle where data_valid is 1.
module zmod_rx_aligner #(
    parameter int N            = 3,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     sync_in,
    input  logic [N*8-1:0] data_in,
    output logic [N*8-1:0] data_out,
    output logic           data_valid,
    output logic           locked,
    output logic [2:0]     shift,
    output logic [15:0]    sync_err_cnt,
    output logic           check_err,
    output logic [15:0]    check_err_cnt,
    output logic [1:0]     fsm_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_CNT8   = LOCK_COUNT[7:0];
    localparam logic [7:0] UNLOCK_CNT8 = UNLOCK_COUNT[7:0];

    state_t         state_q, state_d;
    logic [2:0]     cand_q, cand_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     miss_q, miss_d;
    logic [2:0]     shift_d;
    logic           err_inc;

    logic [7:0]     sync_d1;
    logic [N*8-1:0] data_d1;

    logic           one_hot;
    logic [2:0]     pos;
    logic [3:0]     ones;
    logic [15:0]    sync_win;
    logic           sync_good;
    logic [15:0]    data_win;
    logic [N*8-1:0] aligned;

    assign fsm_state = state_q;
    assign sync_win  = {sync_in, sync_d1};
    assign sync_good = (sync_win[shift +: 8] == 8'h01);

    // Classify the raw sync byte: one-hot flag and the index of its set bit.
    always_comb begin
        ones = 4'd0;
        pos  = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (sync_in[b]) begin
                ones = ones + 4'd1;
                pos  = 3'(b);
            end
        end
        one_hot = (ones == 4'd1);
    end

    // Extract the aligned byte of every lane with the currently applied shift.
    always_comb begin
        aligned  = '0;
        data_win = '0;
        for (int i = 0; i < N; i++) begin
            data_win           = {data_in[8*i +: 8], data_d1[8*i +: 8]};
            aligned[8*i +: 8]  = data_win[shift +: 8];
        end
    end

    // Next-state logic: hunt for a candidate, qualify it, then track sync health.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        shift_d = shift;
        err_inc = 1'b0;
        case (state_q)
            HUNT: begin
                if (one_hot) begin
                    cand_d  = pos;
                    cnt_d   = 8'd1;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (one_hot && (pos == cand_q)) begin
                    if (cnt_q + 8'd1 == LOCK_CNT8) begin
                        shift_d = cand_q;
                        miss_d  = 8'd0;
                        cnt_d   = 8'd0;
                        state_d = LOCKED;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // A broken run is dropped; this byte does not start a new one.
                    cnt_d   = 8'd0;
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (sync_good) begin
                    miss_d = 8'd0;
                end else begin
                    err_inc = 1'b1;
                    if (miss_q + 8'd1 == UNLOCK_CNT8) begin
                        miss_d  = 8'd0;
                        state_d = HUNT;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, qualification counters and the delay line for the byte windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cand_q  <= 3'd0;
            cnt_q   <= 8'd0;
            miss_q  <= 8'd0;
            shift   <= 3'd0;
            sync_d1 <= 8'd0;
            data_d1 <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            shift   <= shift_d;
            sync_d1 <= sync_in;
            data_d1 <= data_in;
        end
    end

    // Registered outputs: aligned data, valid, lock status, saturating error count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            locked       <= 1'b0;
            sync_err_cnt <= 16'd0;
        end else begin
            data_out   <= aligned;
            data_valid <= (state_d == LOCKED);
            locked     <= (state_q == LOCKED);
            if (err_inc && (sync_err_cnt != 16'hFFFF)) begin
                sync_err_cnt <= sync_err_cnt + 16'd1;
            end
        end
    end

`ifdef ZMOD_RX_CHECK_EN
    logic chk_mismatch;
    logic chk_fire;

    // Compare each next aligned byte with the previous output byte plus one.
    always_comb begin
        chk_mismatch = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (aligned[8*i +: 8] != data_out[8*i +: 8] + 8'd1) begin
                chk_mismatch = 1'b1;
            end
        end
    end

    // The first valid byte after lock only seeds the expectation.
    assign chk_fire = (state_d == LOCKED) && data_valid && chk_mismatch;

    // Register the checker flag and its saturating count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            check_err     <= 1'b0;
            check_err_cnt <= 16'd0;
        end else begin
            check_err <= chk_fire;
            if (chk_fire && (check_err_cnt != 16'hFFFF)) begin
                check_err_cnt <= check_err_cnt + 16'd1;
            end
        end
    end
`else
    assign check_err     = 1'b0;
    assign check_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_zmod_rx_aligner.sv
// Bench for zmod_rx_aligner: directed stimulus, a behavioural reference
// model checked every cycle, and hand-computed literal expectations.
module tb_zmod_rx_aligner;

  localparam int N = 3;
  localparam int LOCK_COUNT = 16;
  localparam int UNLOCK_COUNT = 4;

  logic           clk;
  logic           rst_n;
  logic [7:0]     sync_in;
  logic [N*8-1:0] data_in;
  logic [N*8-1:0] data_out;
  logic           data_valid;
  logic           locked;
  logic [2:0]     shift;
  logic [15:0]    sync_err_cnt;
  logic           check_err;
  logic [15:0]    check_err_cnt;
  logic [1:0]     fsm_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 0;

  // transmitter model: per-lane byte counters and bit skew of the raw lanes
  logic [7:0] tx_cnt [N];
  logic [7:0] tx_cur [N];
  logic [7:0] tx_prev [N];
  int         skew;
  bit         corrupt;

  zmod_rx_aligner #(
    .N(N), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .shift(shift), .sync_err_cnt(sync_err_cnt), .check_err(check_err),
    .check_err_cnt(check_err_cnt), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  // mode: 0 hunting, 1 qualifying a candidate, 2 locked
  int         m_mode, m_cand, m_run, m_miss;
  logic [7:0] m_sync_d1;
  logic [7:0] m_data_d1 [N];
  logic [7:0] e_data [N];
  logic       e_valid, e_locked, e_chk;
  logic [2:0] e_shift;
  int         e_err, e_chk_cnt;

  always @(posedge clk) begin : model
    int pos;
    bit oh;
    int nmode;
    logic [2:0] nshift;
    logic [15:0] w;
    bit good;
    bit mism;
    logic [7:0] nd [N];
    if (!rst_n) begin
      m_mode = 0; m_cand = 0; m_run = 0; m_miss = 0; m_sync_d1 = 0;
      for (int i = 0; i < N; i++) begin m_data_d1[i] = 0; e_data[i] = 0; end
      e_valid = 0; e_locked = 0; e_shift = 0; e_err = 0; e_chk = 0; e_chk_cnt = 0;
    end else begin
      oh = ($countones(sync_in) == 1);
      pos = 0;
      for (int b = 0; b < 8; b++) if (sync_in[b]) pos = b;
      w = {sync_in, m_sync_d1} >> e_shift;
      good = (w[7:0] == 8'h01);
      nmode = m_mode;
      nshift = e_shift;
      if (m_mode == 0) begin
        if (oh) begin m_cand = pos; m_run = 1; nmode = 1; end
      end else if (m_mode == 1) begin
        if (oh && pos == m_cand) begin
          m_run++;
          if (m_run == LOCK_COUNT) begin nmode = 2; nshift = 3'(m_cand); m_miss = 0; end
        end else begin
          nmode = 0; m_run = 0;
        end
      end else begin
        if (good) m_miss = 0;
        else begin
          m_miss++;
          if (e_err < 65535) e_err++;
          if (m_miss == UNLOCK_COUNT) begin nmode = 0; m_miss = 0; end
        end
      end
      mism = 0;
      for (int i = 0; i < N; i++) begin
        w = {data_in[8*i +: 8], m_data_d1[i]} >> e_shift;
        nd[i] = w[7:0];
        if (nd[i] != 8'(e_data[i] + 8'd1)) mism = 1;
      end
`ifdef ZMOD_RX_CHECK_EN
      e_chk = mism && e_valid && (nmode == 2);
      if (e_chk && e_chk_cnt < 65535) e_chk_cnt++;
`else
      e_chk = 0;
`endif
      for (int i = 0; i < N; i++) begin
        e_data[i] = nd[i];
        m_data_d1[i] = data_in[8*i +: 8];
      end
      e_locked = (m_mode == 2);
      e_valid = (nmode == 2);
      e_shift = nshift;
      m_mode = nmode;
      m_sync_d1 = sync_in;
    end
  end

  // compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) check("data_out", 32'(data_out[8*i +: 8]), 32'(e_data[i]));
      check("data_valid", 32'(data_valid), 32'(e_valid));
      check("locked", 32'(locked), 32'(e_locked));
      check("shift", 32'(shift), 32'(e_shift));
      check("sync_err_cnt", 32'(sync_err_cnt), e_err);
      check("check_err", 32'(check_err), 32'(e_chk));
      check("check_err_cnt", 32'(check_err_cnt), e_chk_cnt);
      check("fsm_state", 32'(fsm_state), m_mode);
    end
  end

  // ---------------- driver ----------------
  // one byte time: advance the transmitter, present raw skewed bytes
  task automatic step(input logic [7:0] s);
    logic [15:0] w;
    for (int i = 0; i < N; i++) begin
      tx_prev[i] = tx_cur[i];
      tx_cur[i] = tx_cnt[i] ^ ((corrupt && i == 1) ? 8'h5A : 8'h00);
      tx_cnt[i] = tx_cnt[i] + 8'd1;
      w = {tx_cur[i], tx_prev[i]} << skew;
      data_in[8*i +: 8] = w[15:8];
    end
    corrupt = 0;
    sync_in = s;
    @(negedge clk);
  endtask

  task automatic check_lanes_aligned(input string name);
    for (int i = 0; i < N; i++) check(name, 32'(data_out[8*i +: 8]), 32'(tx_prev[i]));
  endtask

  initial begin
    int n, nv, np;
    logic [15:0] c0;
    rst_n = 0; sync_in = 0; data_in = 0; skew = 3; corrupt = 0;
    for (int i = 0; i < N; i++) begin
      tx_cnt[i] = 8'(i * 40 + 7); tx_cur[i] = 0; tx_prev[i] = 0;
    end
    cmp_en = 1;
    repeat (3) @(negedge clk);
    check("rst_locked", 32'(locked), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_shift", 32'(shift), 0);
    check("rst_sync_err", 32'(sync_err_cnt), 0);
    check("rst_state", 32'(fsm_state), 0);
    rst_n = 1;

    // clean sync at skew 3: valid after 16 bytes, locked after 17
    n = 0; nv = 0;
    while (!locked && n < 40) begin
      step(8'h08); n++;
      if (data_valid && nv == 0) nv = n;
    end
    check("lock_latency", n, 17);
    check("valid_latency", nv, 16);
    check("lock_shift", 32'(shift), 3);
    check("lock_sync_err", 32'(sync_err_cnt), 0);
    repeat (3) begin step(8'h08); check_lanes_aligned("lane_align3"); end

    // glitch shorter than UNLOCK_COUNT: keep lock and shift
    repeat (3) step(8'h00);
    repeat (2) step(8'h08);
    check("glitch_locked", 32'(locked), 1);
    check("glitch_shift", 32'(shift), 3);
    check("glitch_err", 32'(sync_err_cnt), 3);

    // four bad words drop lock
    repeat (4) step(8'h00);
    step(8'h08);
    check("unlock_valid", 32'(data_valid), 0);
    step(8'h08);
    check("unlock_locked", 32'(locked), 0);
    check("unlock_err", 32'(sync_err_cnt), 7);

    // non one-hot sync never qualifies
    repeat (20) begin
      step(8'h0C);
      check("nonhot_state", 32'(fsm_state), 0);
      check("nonhot_locked", 32'(locked), 0);
      check("nonhot_valid", 32'(data_valid), 0);
    end

    // candidate broken by a different position, then relock at shift 4
    repeat (10) step(8'h08);
    check("verify_state", 32'(fsm_state), 1);
    skew = 4;
    step(8'h10);
    check("break_state", 32'(fsm_state), 0);
    check("break_locked", 32'(locked), 0);
    n = 0;
    while (fsm_state != 2'd2 && n < 40) begin step(8'h10); n++; end
    check("relock_bytes", n, 16);
    check("relock_shift", 32'(shift), 4);
    check("relock_err_kept", 32'(sync_err_cnt), 7);
    step(8'h10);
    check("relock_locked", 32'(locked), 1);
    repeat (4) begin step(8'h10); check_lanes_aligned("lane_align4"); end

    // single corrupted byte on lane 1
    c0 = check_err_cnt;
    corrupt = 1;
    step(8'h10);
    np = 0;
    repeat (6) begin step(8'h10); np += int'(check_err); end
`ifdef ZMOD_RX_CHECK_EN
    check("chk_pulses", np, 2);
    check("chk_cnt_delta", 32'(16'(check_err_cnt - c0)), 2);
`else
    check("chk_pulses", np, 0);
    check("chk_cnt_delta", 32'(16'(check_err_cnt - c0)), 0);
`endif

    // one-cycle reset while locked
    rst_n = 0;
    step(8'h10);
    check("midrst_data", 32'(data_out), 0);
    check("midrst_valid", 32'(data_valid), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_shift", 32'(shift), 0);
    check("midrst_err", 32'(sync_err_cnt), 0);
    check("midrst_chk", 32'(check_err_cnt), 0);
    check("midrst_state", 32'(fsm_state), 0);
    rst_n = 1;
    n = 0;
    while (!locked && n < 40) begin step(8'h10); n++; end
    check("midrst_relock", n, 17);
    check("midrst_shift4", 32'(shift), 4);
    repeat (3) step(8'h10);

    cmp_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
